// File: rtl/mm2s_rd_engine.sv
// MM2S read engine: splits a (byte address, byte length) read command into
// 4 KB-safe AXI3 INCR bursts on HP0 and streams the returned data downstream.
module mm2s_rd_engine #(
    parameter int          MAX_BURST = 16,
    parameter logic [3:0]  ARCACHE   = 4'b0011,
    parameter logic [3:0]  ARID      = 4'd0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] i_rd_cmd_addr,
    input  logic [22:0] i_rd_cmd_length,
    input  logic        i_rd_cmd_req,
    output logic        o_rd_cmd_ack,

    input  logic        i_rd_ready,
    output logic        o_rd_valid,
    output logic [63:0] o_rd_data,
    output logic        o_rd_last,
    output logic        o_read_finish,
    output logic        o_rd_err,
    output logic        o_busy,

    input  logic        hp0_arready,
    output logic        hp0_arvalid,
    output logic [3:0]  hp0_arid,
    output logic [31:0] hp0_araddr,
    output logic [3:0]  hp0_arlen,
    output logic [2:0]  hp0_arsize,
    output logic [1:0]  hp0_arburst,
    output logic [2:0]  hp0_arprot,
    output logic [3:0]  hp0_arcache,

    input  logic [63:0] hp0_rdata,
    input  logic [1:0]  hp0_rresp,
    input  logic        hp0_rlast,
    input  logic        hp0_rvalid,
    output logic        hp0_rready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state;
    logic [28:0] addr_q;
    logic [19:0] remaining;
    logic [4:0]  burst_len;
    logic [4:0]  beat_cnt;
    logic [3:0]  arlen_q;
    logic        ack_q;
    logic        err_q;

    logic [19:0] cmd_beats;
    logic [4:0]  first_burst;
    logic [28:0] next_addr;
    logic [19:0] next_rem;
    logic [4:0]  next_burst;
    logic        r_hs;
    logic        last_beat;
    logic        unused_bits;

    // Beats until the next 4 KB boundary bound the burst alongside MAX_BURST and the remainder.
    function automatic logic [4:0] calc_burst(input logic [8:0] qoff, input logic [19:0] rem);
        logic [19:0] b;
        logic [19:0] to_bnd;
        to_bnd = 20'd512 - {11'd0, qoff};
        b = 20'(MAX_BURST);
        if (rem < b)
            b = rem;
        if (to_bnd < b)
            b = to_bnd;
        return 5'(b);
    endfunction

    assign cmd_beats   = i_rd_cmd_length[22:3];
    assign first_burst = calc_burst(i_rd_cmd_addr[11:3], cmd_beats);
    assign next_addr   = addr_q + 29'(burst_len);
    assign next_rem    = remaining - 20'd1;
    assign next_burst  = calc_burst(next_addr[8:0], next_rem);
    assign r_hs        = (state == S_DATA) && hp0_rvalid && i_rd_ready;
    assign last_beat   = (beat_cnt == burst_len - 5'd1);
    assign unused_bits = ^{i_rd_cmd_addr[2:0], i_rd_cmd_length[2:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            remaining <= '0;
            burst_len <= '0;
            beat_cnt  <= '0;
            arlen_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_rd_cmd_req) begin
                        ack_q     <= 1'b1;
                        err_q     <= 1'b0;
                        addr_q    <= i_rd_cmd_addr[31:3];
                        remaining <= cmd_beats;
                        if (cmd_beats == '0) begin
                            state <= S_DONE;
                        end else begin
                            burst_len <= first_burst;
                            arlen_q   <= 4'(first_burst - 5'd1);
                            state     <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    if (hp0_arready) begin
                        beat_cnt <= '0;
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (r_hs) begin
                        beat_cnt  <= beat_cnt + 5'd1;
                        remaining <= next_rem;
                        if ((hp0_rresp != 2'b00) || (hp0_rlast != last_beat))
                            err_q <= 1'b1;
                        if (last_beat) begin
                            addr_q <= next_addr;
                            if (remaining == 20'd1) begin
                                state <= S_DONE;
                            end else begin
                                burst_len <= next_burst;
                                arlen_q   <= 4'(next_burst - 5'd1);
                                state     <= S_ADDR;
                            end
                        end
                    end
                end
                default: begin
                    // A zero-length command enters DONE while ack is still high; hold one
                    // extra cycle so ack and finish never coincide.
                    if (!ack_q)
                        state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_rd_cmd_ack  = ack_q;
    assign o_read_finish = (state == S_DONE) && !ack_q;
    assign o_rd_err      = err_q;
    assign o_busy        = (state != S_IDLE);

    assign o_rd_valid    = (state == S_DATA) && hp0_rvalid;
    assign o_rd_data     = hp0_rdata;
    assign o_rd_last     = (state == S_DATA) && hp0_rvalid && (remaining == 20'd1);
    assign hp0_rready    = (state == S_DATA) && i_rd_ready;

    assign hp0_arvalid   = (state == S_ADDR);
    assign hp0_araddr    = {addr_q, 3'b000};
    assign hp0_arlen     = arlen_q;
    assign hp0_arid      = ARID;
    assign hp0_arsize    = 3'b011;
    assign hp0_arburst   = 2'b01;
    assign hp0_arprot    = 3'b000;
    assign hp0_arcache   = ARCACHE;

endmodule

// File: tb/tb_mm2s_rd_engine.sv
// Bench for mm2s_rd_engine: randomized HP0 read slave backed by a synthetic RAM,
// with expected AR and data streams derived from the command by a burst-splitting model.
module tb_mm2s_rd_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_rd_cmd_addr = '0;
    logic [22:0] i_rd_cmd_length = '0;
    logic        i_rd_cmd_req = 1'b0;
    logic        o_rd_cmd_ack;
    logic        i_rd_ready = 1'b1;
    logic        o_rd_valid;
    logic [63:0] o_rd_data;
    logic        o_rd_last;
    logic        o_read_finish;
    logic        o_rd_err;
    logic        o_busy;
    logic        hp0_arready = 1'b0;
    logic        hp0_arvalid;
    logic [3:0]  hp0_arid;
    logic [31:0] hp0_araddr;
    logic [3:0]  hp0_arlen;
    logic [2:0]  hp0_arsize;
    logic [1:0]  hp0_arburst;
    logic [2:0]  hp0_arprot;
    logic [3:0]  hp0_arcache;
    logic [63:0] hp0_rdata = '0;
    logic [1:0]  hp0_rresp = '0;
    logic        hp0_rlast = 1'b0;
    logic        hp0_rvalid = 1'b0;
    logic        hp0_rready;

    mm2s_rd_engine #(.MAX_BURST(16), .ARCACHE(4'b0011), .ARID(4'd0)) dut (
        .clk(clk), .rst(rst),
        .i_rd_cmd_addr(i_rd_cmd_addr), .i_rd_cmd_length(i_rd_cmd_length),
        .i_rd_cmd_req(i_rd_cmd_req), .o_rd_cmd_ack(o_rd_cmd_ack),
        .i_rd_ready(i_rd_ready), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
        .o_rd_last(o_rd_last), .o_read_finish(o_read_finish), .o_rd_err(o_rd_err),
        .o_busy(o_busy),
        .hp0_arready(hp0_arready), .hp0_arvalid(hp0_arvalid), .hp0_arid(hp0_arid),
        .hp0_araddr(hp0_araddr), .hp0_arlen(hp0_arlen), .hp0_arsize(hp0_arsize),
        .hp0_arburst(hp0_arburst), .hp0_arprot(hp0_arprot), .hp0_arcache(hp0_arcache),
        .hp0_rdata(hp0_rdata), .hp0_rresp(hp0_rresp), .hp0_rlast(hp0_rlast),
        .hp0_rvalid(hp0_rvalid), .hp0_rready(hp0_rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM contents as a fixed function of the 64-bit word address.
    function automatic logic [63:0] mem_word(input logic [28:0] q);
        return {32'hA5A5_0000 ^ {3'b000, q}, ~{3'b000, q}};
    endfunction

    // Sampled at negedge, consumed by the slave after the following posedge.
    logic        ar_hs_s = 1'b0;
    logic        r_hs_s = 1'b0;
    logic        rst_s = 1'b1;
    logic [28:0] ar_addr_s = '0;
    logic [3:0]  ar_len_s = '0;

    logic [31:0] obs_ar_addr[$];
    logic [3:0]  obs_ar_len[$];
    logic [63:0] obs_data[$];
    logic        obs_last[$];
    int last_cyc = -10, fin_cyc = -10, ack_cyc = -10;
    int fin_cnt = 0, ack_cnt = 0, arv_cnt = 0, rdy_mis = 0, vld_mis = 0;

    logic [28:0] sq_addr[$];
    logic [3:0]  sq_len[$];
    int s_beat = 0;
    int g_total = 0;
    int err_abs = -1;
    int rdy_mode = 0;

    always @(negedge clk) begin
        ar_hs_s   = hp0_arvalid && hp0_arready;
        r_hs_s    = hp0_rvalid && hp0_rready;
        rst_s     = rst;
        ar_addr_s = hp0_araddr[31:3];
        ar_len_s  = hp0_arlen;
        if (ar_hs_s) begin
            obs_ar_addr.push_back(hp0_araddr);
            obs_ar_len.push_back(hp0_arlen);
        end
        if (o_rd_valid && i_rd_ready) begin
            obs_data.push_back(o_rd_data);
            obs_last.push_back(o_rd_last);
            if (o_rd_last) last_cyc = cyc;
        end
        if (o_read_finish) begin fin_cnt++; fin_cyc = cyc; end
        if (o_rd_cmd_ack) begin ack_cnt++; ack_cyc = cyc; end
        if (hp0_arvalid) arv_cnt++;
        if (sq_addr.size() > 0 && hp0_rready !== i_rd_ready) rdy_mis++;
        if (sq_addr.size() > 0 && o_rd_valid !== hp0_rvalid) vld_mis++;
    end

    // HP0 read slave: random arready, random R gaps, rvalid held until accepted.
    always @(posedge clk) begin
        #1;
        if (rst_s) begin
            sq_addr.delete();
            sq_len.delete();
            s_beat = 0;
            hp0_arready = 1'b0;
            hp0_rvalid = 1'b0;
            hp0_rlast = 1'b0;
            hp0_rresp = 2'b00;
        end else begin
            if (ar_hs_s) begin
                sq_addr.push_back(ar_addr_s);
                sq_len.push_back(ar_len_s);
            end
            if (r_hs_s) begin
                g_total++;
                s_beat++;
                if (s_beat > int'(sq_len[0])) begin
                    void'(sq_addr.pop_front());
                    void'(sq_len.pop_front());
                    s_beat = 0;
                end
            end
            if (!(hp0_rvalid && !r_hs_s)) begin
                if (sq_addr.size() > 0 && $urandom_range(0, 3) != 0) begin
                    hp0_rvalid = 1'b1;
                    hp0_rdata  = mem_word(sq_addr[0] + 29'(s_beat));
                    hp0_rlast  = (s_beat == int'(sq_len[0]));
                    hp0_rresp  = (g_total == err_abs) ? 2'b10 : 2'b00;
                end else begin
                    hp0_rvalid = 1'b0;
                end
            end
            hp0_arready = ($urandom_range(0, 2) != 0);
        end
        case (rdy_mode)
            0:       i_rd_ready = 1'b1;
            1:       i_rd_ready = ~i_rd_ready;
            default: i_rd_ready = ($urandom_range(0, 1) == 1);
        endcase
    end

    typedef struct {
        int   ack_ok;
        int   timeout;
        int   ar_err;
        int   data_err;
        int   fin_ok;
        int   idle_ok;
        logic err_ack;
        logic err_fin;
        logic err_idle;
        logic exp_err;
        int   n_ar;
        int   acks;
        int   arv;
    } res_t;

    task automatic run_cmd(input logic [31:0] a, input logic [22:0] l, input int mode,
                           input int err_rel, input bit poke_busy, output res_t r);
        logic [31:0] ea[$];
        logic [3:0]  el[$];
        logic [63:0] ed[$];
        logic        elast[$];
        logic [28:0] qa;
        int rem, b, beats, ar0, d0, a0, f0, v0;
        bit done;
        qa = a[31:3];
        beats = int'(l[22:3]);
        rem = beats;
        while (rem > 0) begin
            b = 16;
            if (rem < b) b = rem;
            if (512 - int'(qa[8:0]) < b) b = 512 - int'(qa[8:0]);
            ea.push_back({qa, 3'b000});
            el.push_back(4'(b - 1));
            for (int i = 0; i < b; i++) begin
                ed.push_back(mem_word(qa + 29'(i)));
                elast.push_back(rem == b && i == b - 1);
            end
            qa = qa + 29'(b);
            rem -= b;
        end
        r.exp_err = (err_rel >= 0 && err_rel < beats);
        rdy_mode = mode;
        err_abs = (err_rel >= 0) ? g_total + err_rel : -1;
        ar0 = obs_ar_addr.size(); d0 = obs_data.size();
        a0 = ack_cnt; f0 = fin_cnt; v0 = arv_cnt;

        @(posedge clk); #1;
        i_rd_cmd_req = 1'b1; i_rd_cmd_addr = a; i_rd_cmd_length = l;
        @(posedge clk); #1;
        i_rd_cmd_req = 1'b0;
        @(negedge clk);
        r.ack_ok  = (o_rd_cmd_ack === 1'b1 && o_busy === 1'b1 && hp0_arvalid === (beats != 0));
        r.err_ack = o_rd_err;
        done = 0;
        for (int i = 0; i < 4000; i++) begin
            if (fin_cnt > f0) begin done = 1; break; end
            @(negedge clk);
            if (poke_busy && i == 3) i_rd_cmd_req = 1'b1;
            if (poke_busy && i == 12) i_rd_cmd_req = 1'b0;
        end
        i_rd_cmd_req = 1'b0;
        r.timeout = !done;
        r.err_fin = o_rd_err;
        r.fin_ok  = done && (beats == 0 ? fin_cyc == ack_cyc + 1 : fin_cyc == last_cyc + 1);
        @(negedge clk);
        r.idle_ok  = (o_busy === 1'b0);
        r.err_idle = o_rd_err;
        r.n_ar = obs_ar_addr.size() - ar0;
        r.acks = ack_cnt - a0;
        r.arv  = arv_cnt - v0;
        r.ar_err = (r.n_ar > ea.size()) ? r.n_ar - ea.size() : ea.size() - r.n_ar;
        for (int i = 0; i < ea.size() && i < r.n_ar; i++)
            if (obs_ar_addr[ar0 + i] !== ea[i] || obs_ar_len[ar0 + i] !== el[i]) r.ar_err++;
        r.data_err = ((obs_data.size() - d0) > ed.size()) ? (obs_data.size() - d0) - ed.size()
                                                           : ed.size() - (obs_data.size() - d0);
        for (int i = 0; i < ed.size() && d0 + i < obs_data.size(); i++)
            if (obs_data[d0 + i] !== ed[i] || obs_last[d0 + i] !== elast[i]) r.data_err++;
    endtask

    task automatic test_reset();
        logic [7:0] flags;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        flags = {o_rd_cmd_ack, o_rd_valid, o_rd_last, o_read_finish, o_rd_err, o_busy,
                 hp0_arvalid, hp0_rready};
        checks++;
        if (flags !== 8'h00) begin failures++; $display("FAIL reset_flags: got %b expected 00000000", flags); end
        checks++;
        if ({hp0_araddr, hp0_arlen} !== 36'h0) begin
            failures++; $display("FAIL reset_ar: got addr %h len %h expected 0", hp0_araddr, hp0_arlen);
        end
        checks++;
        if ({hp0_arsize, hp0_arburst, hp0_arprot, hp0_arcache, hp0_arid} !== {3'b011, 2'b01, 3'b000, 4'b0011, 4'd0}) begin
            failures++; $display("FAIL ar_consts: got %b %b %b %b %b", hp0_arsize, hp0_arburst, hp0_arprot, hp0_arcache, hp0_arid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_burst();
        res_t r;
        run_cmd(32'h0000_1000, 23'd128, 0, -1, 0, r);
        checks++; if (r.ack_ok !== 1) begin failures++; $display("FAIL single_ack: got %0d expected 1", r.ack_ok); end
        checks++; if (r.timeout !== 0) begin failures++; $display("FAIL single_timeout: got %0d expected 0", r.timeout); end
        checks++; if (r.n_ar !== 1 || obs_ar_addr[$] !== 32'h1000 || obs_ar_len[$] !== 4'd15) begin
            failures++; $display("FAIL single_ar: got n=%0d addr=%h len=%0d expected n=1 addr=1000 len=15", r.n_ar, obs_ar_addr[$], obs_ar_len[$]);
        end
        checks++; if (r.data_err !== 0) begin failures++; $display("FAIL single_data: got %0d mismatches expected 0", r.data_err); end
        checks++; if (r.fin_ok !== 1 || r.idle_ok !== 1) begin
            failures++; $display("FAIL single_finish: got fin_ok=%0d idle_ok=%0d expected 1 1", r.fin_ok, r.idle_ok);
        end
    endtask

    task automatic test_split();
        res_t r;
        run_cmd(32'h0000_0100, 23'd200, 2, -1, 0, r);
        checks++; if (r.ar_err !== 0 || r.n_ar !== 2) begin
            failures++; $display("FAIL split_ar: got n=%0d mismatches=%0d expected n=2 mismatches=0", r.n_ar, r.ar_err);
        end
        checks++; if (r.data_err !== 0 || r.timeout !== 0) begin
            failures++; $display("FAIL split_data: got mismatches=%0d timeout=%0d expected 0 0", r.data_err, r.timeout);
        end
        checks++; if (r.fin_ok !== 1) begin failures++; $display("FAIL split_finish: got %0d expected 1", r.fin_ok); end
    endtask

    task automatic test_boundary();
        res_t r;
        run_cmd(32'h0000_0FE0, 23'd64, 2, -1, 0, r);
        checks++; if (r.n_ar !== 2 || obs_ar_addr[$-1] !== 32'h0FE0 || obs_ar_len[$-1] !== 4'd3 ||
                      obs_ar_addr[$] !== 32'h1000 || obs_ar_len[$] !== 4'd3) begin
            failures++; $display("FAIL boundary_ar: got n=%0d %h/%0d %h/%0d expected 2 0fe0/3 1000/3",
                                 r.n_ar, obs_ar_addr[$-1], obs_ar_len[$-1], obs_ar_addr[$], obs_ar_len[$]);
        end
        checks++; if (r.data_err !== 0) begin failures++; $display("FAIL boundary_data: got %0d mismatches expected 0", r.data_err); end
    endtask

    task automatic test_backpressure();
        res_t r;
        int m0, v0;
        m0 = rdy_mis; v0 = vld_mis;
        run_cmd({20'($urandom), 12'h000} + 32'($urandom_range(0, 511)) * 8, 23'd256, 1, -1, 0, r);
        checks++; if (r.data_err !== 0 || r.ar_err !== 0) begin
            failures++; $display("FAIL bp_stream: got data=%0d ar=%0d mismatches expected 0 0", r.data_err, r.ar_err);
        end
        checks++; if (rdy_mis - m0 !== 0 || vld_mis - v0 !== 0) begin
            failures++; $display("FAIL bp_passthru: got rready_diff=%0d rvalid_diff=%0d expected 0 0", rdy_mis - m0, vld_mis - v0);
        end
    endtask

    task automatic test_zero_and_busy();
        res_t r;
        run_cmd(32'h0000_2000, 23'd7, 0, -1, 0, r);
        checks++; if (r.ack_ok !== 1 || r.fin_ok !== 1) begin
            failures++; $display("FAIL zero_timing: got ack_ok=%0d fin_ok=%0d expected 1 1", r.ack_ok, r.fin_ok);
        end
        checks++; if (r.arv !== 0 || r.n_ar !== 0) begin
            failures++; $display("FAIL zero_no_ar: got arvalid_cycles=%0d ars=%0d expected 0 0", r.arv, r.n_ar);
        end
        run_cmd(32'h0001_0040, 23'd512, 1, -1, 1, r);
        checks++; if (r.acks !== 1) begin failures++; $display("FAIL busy_req: got %0d acks expected 1", r.acks); end
        checks++; if (r.data_err !== 0) begin failures++; $display("FAIL busy_data: got %0d mismatches expected 0", r.data_err); end
    endtask

    task automatic test_error_and_reset();
        res_t r;
        int d0;
        logic [7:0] flags;
        run_cmd(32'h0000_0300, 23'd96, 2, 2, 0, r);
        checks++; if (r.err_fin !== 1'b1 || r.err_idle !== 1'b1) begin
            failures++; $display("FAIL err_sticky: got fin=%b idle=%b expected 1 1", r.err_fin, r.err_idle);
        end
        run_cmd(32'h0000_0400, 23'd40, 0, -1, 0, r);
        checks++; if (r.err_ack !== 1'b0 || r.err_fin !== 1'b0) begin
            failures++; $display("FAIL err_clear: got ack=%b fin=%b expected 0 0", r.err_ack, r.err_fin);
        end

        rdy_mode = 0;
        err_abs = g_total;
        d0 = obs_data.size();
        @(posedge clk); #1;
        i_rd_cmd_req = 1'b1; i_rd_cmd_addr = 32'h0000_5000; i_rd_cmd_length = 23'd512;
        @(posedge clk); #1;
        i_rd_cmd_req = 1'b0;
        for (int i = 0; i < 500 && obs_data.size() < d0 + 3; i++) @(negedge clk);
        checks++; if (obs_data.size() < d0 + 3 || o_rd_err !== 1'b1) begin
            failures++; $display("FAIL rst_pre: got beats=%0d err=%b expected >=3 1", obs_data.size() - d0, o_rd_err);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        flags = {o_rd_cmd_ack, o_rd_valid, o_rd_last, o_read_finish, o_rd_err, o_busy,
                 hp0_arvalid, hp0_rready};
        checks++; if (flags !== 8'h00 || hp0_araddr !== 32'h0 || hp0_arlen !== 4'h0) begin
            failures++; $display("FAIL rst_mid: got flags=%b addr=%h len=%h expected 0", flags, hp0_araddr, hp0_arlen);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_cmd(32'h0000_6FC0, 23'd300, 2, -1, 0, r);
        checks++; if (r.ack_ok !== 1 || r.ar_err !== 0 || r.data_err !== 0 || r.err_fin !== 1'b0) begin
            failures++; $display("FAIL rst_after: got ack=%0d ar=%0d data=%0d err=%b expected 1 0 0 0",
                                 r.ack_ok, r.ar_err, r.data_err, r.err_fin);
        end
    endtask

    task automatic test_random();
        res_t r;
        logic [31:0] a;
        logic [22:0] l;
        for (int n = 0; n < 8; n++) begin
            a = $urandom;
            if (n % 2 == 0) a[11:0] = 12'hF00 + 12'($urandom_range(0, 31)) * 12'd8;
            if (n == 7) a = 32'hFFFF_FF80;
            l = 23'($urandom_range(0, 1000));
            run_cmd(a, l, 2, -1, 0, r);
            checks++; if (r.timeout !== 0 || r.ar_err !== 0 || r.data_err !== 0 || r.fin_ok !== 1 || r.idle_ok !== 1) begin
                failures++; $display("FAIL random_%0d: addr=%h len=%0d got to=%0d ar=%0d data=%0d fin=%0d idle=%0d expected 0 0 0 1 1",
                                     n, a, l, r.timeout, r.ar_err, r.data_err, r.fin_ok, r.idle_ok);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_split();
        test_boundary();
        test_backpressure();
        test_zero_and_busy();
        test_error_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
